// File: rtl/credit_rx_buf_if.sv
// ============================================================
// credit_rx_buf_if : link and consumer handshake bundle for credit_rx_buf
// Rev 1.0
// ============================================================
`default_nettype none

interface credit_rx_buf_if #(
  parameter int DW = 8,
  parameter int BW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          load_first_credits;
  logic [BW-1:0] first_credits;
  logic          credit_in;

  // master: link sender plus downstream consumer
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, load_first_credits, first_credits, credit_in
  );

  // slave: the receive buffer itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, load_first_credits, first_credits, credit_in
  );
endinterface

`default_nettype wire

// File: rtl/credit_rx_buf.sv
// ============================================================
// credit_rx_buf : credit-link receive FIFO; optional CREDIT_RX_CHK_EN adds protocol_err
// Rev 1.0
// ============================================================
`default_nettype none

module credit_rx_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int BW    = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_b,
  credit_rx_buf_if.slave  bus
`ifdef CREDIT_RX_CHK_EN
  ,
  output logic            protocol_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_full = CW'(DEPTH);
  localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_ADV = 2'd1,
    ST_RUN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          credit_q, credit_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic w_run;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_load;

  assign w_run  = (state_q == ST_RUN);
  assign w_full = (count_q == c_full);
  assign w_pop  = (count_q != '0) && bus.out_ready;
  // a full buffer still accepts a beat when the head leaves in the same cycle
  assign w_push = bus.in_valid && w_run && (!w_full || w_pop);

  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_ADV;
      ST_ADV: begin
        state_d = ST_RUN;
        w_load  = 1'b1;
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = w_pop;
    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= ST_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // storage carries no reset; stale entries are unreachable once count is zero
  always_ff @(posedge clk) begin
    if (rst_b && w_push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_valid          = (count_q != '0);
  assign bus.out_data           = mem_q[rd_ptr_q];
  assign bus.load_first_credits = w_load;
  assign bus.first_credits      = BW'(DEPTH);
  assign bus.credit_in          = credit_q;

`ifdef CREDIT_RX_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.in_valid && (!w_run || (w_full && !w_pop))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign protocol_err = err_q;
`endif

endmodule

`default_nettype wire

// File: doc/credit_rx_buf.md
Name: credit_rx_buf

Overview:
- Receiver end of the credit-based link; pairs with the sender-side credit counter.
- Advertises its buffer depth once after reset and stores incoming beats in a FIFO.
- Returns one credit pulse per entry drained by the downstream consumer.
- Sits at the ingress of a consuming block, facing the link sender.

Parameters:
- DW, 8, data width of one beat.
- DEPTH, 8, FIFO entries; equals the advertised credit count; any value 2..(2**BW - 1); power of two not required.
- BW, 4, width of first_credits; must satisfy DEPTH <= 2**BW - 1.

Ports:
- clk  input  1  clock.
- rst_b  input  1  reset, synchronous, active-low.
- in_valid  input  1  sender pushes one beat this cycle; no ready, backpressure is by credit only.
- in_data  input  DW  beat payload.
- out_valid  output  1  FIFO non-empty.
- out_data  output  DW  head entry; valid when out_valid=1.
- out_ready  input  1  consumer accepts head; pop when out_valid && out_ready.
- load_first_credits  output  1  one-cycle pulse advertising the initial credit count.
- first_credits  output  BW  constant DEPTH; meaningful while load_first_credits=1.
- credit_in  output  1  one-cycle credit return pulse to the sender, one per pop.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-low, sampled on the clk rising edge.
- Values while rst_b=0: FSM=RST; rd_ptr=wr_ptr=count=0; out_valid=0; load_first_credits=0; credit_in=0.
- Storage array is not reset; out_data is don't-care while out_valid=0.
- FSM:
  - RST -> ADV on the first edge with rst_b=1.
  - ADV: load_first_credits=1 for exactly one cycle; first_credits=DEPTH; then -> RUN.
  - RUN holds until reset.
  - load_first_credits is never reasserted outside ADV.
- Push:
  - In RUN, in_valid=1 writes mem[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0; count+1.
  - in_valid outside RUN is dropped (protocol violation).
- Pop:
  - out_valid && out_ready reads head; rd_ptr wraps DEPTH-1 -> 0; count-1.
- Simultaneous push and pop:
  - Both pointers advance; count unchanged.
  - On an empty FIFO, the pushed beat is not visible until the next cycle; no fall-through.
- Push while full (count==DEPTH) with no pop in the same cycle: beat dropped; pointers and count unchanged.
- Push while full with a same-cycle pop: legal; the freed slot is reused.
- Latency:
  - Push at edge N -> out_valid=1 after edge N (first-word show-ahead).
  - out_data is driven directly from mem[rd_ptr].
- Credit return:
  - credit_in is registered; it equals the pop handshake of the previous cycle.
  - At most one pulse per cycle; never merged or delayed further.
- Credit accounting invariant: count plus credits held by the sender equals DEPTH at all times after ADV.
- Reset mid-operation:
  - All contents and outstanding credit returns are discarded.
  - A fresh ADV pulse is issued after release.
  - The sender's counter is expected to reload from this pulse.
- count width is clog2(DEPTH+1); pointer width is clog2(DEPTH).

Optional Feature:
- Macro: CREDIT_RX_CHK_EN.
- Defined:
  - Adds output port protocol_err (1 bit), sticky.
  - Set on the edge after in_valid=1 while FSM!=RUN.
  - Set on the edge after in_valid=1 while count==DEPTH with no same-cycle pop.
  - Cleared only by reset; dropped-beat behaviour is unchanged.
- Not defined:
  - Port absent; no checking logic.
  - Violating pushes are silently dropped.

Test Plan:
- Reset release -> load_first_credits=1 with first_credits=8 on exactly one cycle (the first cycle after rst_b rises); 0 thereafter; credit_in=0, out_valid=0 throughout.
- Push 0x11,0x22,0x33 on consecutive cycles with out_ready=0, then out_ready=1 -> out_data 0x11,0x22,0x33 on successive cycles; three credit_in pulses, each one cycle after its pop.
- Fill to 8 entries, push a 9th 0xFF with no pop -> count stays 8; 0xFF never appears; with CREDIT_RX_CHK_EN, protocol_err=1 next cycle and stays 1.
- Full FIFO with same-cycle push 0xAA and pop -> count stays 8; 0xAA emerges as the 8th beat after the pop; one credit_in pulse.
- Stream 20 beats with out_ready=1 and in_valid every cycle -> pointers wrap twice; data order preserved; exactly 20 credit_in pulses; count never exceeds 1.
- Assert rst_b=0 for one cycle with 5 entries held -> out_valid=0 on the next cycle; no credit_in for the discarded entries; new load_first_credits pulse with value 8 after release.
